// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_IDLE,
    S_ARMED,
    S_MEASURE,
    S_CHECK,
    S_UPDATE,
    S_FAIL
  } state_t;

  localparam int OVERSAMPLE_LOG2 = 4;
  localparam logic [7:0] SYNC_CHAR = 8'h55;

  // 8 bit times divided by 16 samples per bit, rounded to nearest.
  localparam int ROUND_SHIFT = OVERSAMPLE_LOG2 + 3;
  localparam int ROUND_ADD = 1 << (ROUND_SHIFT - 1);

endpackage

// File: rtl/uart_autobaud_ctrl_rx_edge_sync.sv
// Two-flop synchronizer for the rx pad with single-cycle rise/fall pulses.
module rx_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // Flops reset high so an idle line produces no spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Measures a 0x55 sync character on rx and derives the 16x baud timer terminal count.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int BITS          = 11,
  parameter int DEFAULT_FINAL = 26,
  parameter int IDLE_MIN      = 16,
  parameter int MIN_FINAL     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            start,
  output logic [BITS-1:0] final_value,
  output logic            timer_enable,
  output logic            timer_clr_n,
  output logic            busy,
  output logic            locked,
  output logic            error
);

  localparam int CNT_W = BITS + 7;
  localparam int IW    = $clog2(IDLE_MIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   Q_LO    = (CNT_W + 1)'(MIN_FINAL + 1);
  localparam logic [CNT_W:0]   Q_HI    = (CNT_W + 1)'(2 ** BITS);

  state_t state, state_next;

  logic rx_s, rx_rise, rx_fall;
  logic [CNT_W-1:0] cnt, cnt_inc, s_len, c_len;
  logic [2:0]       fall_cnt;
  logic [IW-1:0]    idle_cnt;
  logic [CNT_W+3:0] s_ext, c_ext, s7, s9;
  logic [CNT_W:0]   q_full;
  logic [BITS-1:0]  q_val;
  logic             ratio_ok, range_ok;

  rx_edge_sync u_sync (
    .clk  (clk),
    .rst  (reset),
    .d    (rx),
    .sync (rx_s),
    .rise (rx_rise),
    .fall (rx_fall)
  );

  // cnt_inc is the cycle count since the start edge, inclusive of this cycle.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign s_ext    = {4'b0, s_len};
  assign c_ext    = {4'b0, c_len};
  assign s7       = (s_ext << 3) - s_ext;
  assign s9       = (s_ext << 3) + s_ext;
  assign ratio_ok = (c_ext >= s7) && (c_ext <= s9);

  // q_full is q+1, kept unsigned so a zero result is caught by the range check.
  assign q_full   = ({1'b0, c_len} + (CNT_W + 1)'(ROUND_ADD)) >> ROUND_SHIFT;
  assign q_val    = q_full[BITS-1:0] - BITS'(1);
  assign range_ok = (q_full >= Q_LO) && (q_full <= Q_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (start) state_next = S_SYNC_IDLE;
      S_SYNC_IDLE: if (idle_cnt == IW'(IDLE_MIN)) state_next = S_ARMED;
      S_ARMED:     if (rx_fall) state_next = S_MEASURE;
      S_MEASURE: begin
        if (rx_fall && fall_cnt == 3'd3) state_next = S_CHECK;
        else if (cnt_inc == CNT_MAX)     state_next = S_FAIL;
      end
      S_CHECK:     state_next = (ratio_ok && range_ok) ? S_UPDATE : S_FAIL;
      S_UPDATE:    state_next = S_IDLE;
      S_FAIL:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      final_value <= BITS'(DEFAULT_FINAL);
      locked      <= 1'b0;
      cnt         <= '0;
      s_len       <= '0;
      c_len       <= '0;
      fall_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (start) locked <= 1'b0;
        end
        S_SYNC_IDLE: idle_cnt <= rx_s ? idle_cnt + IW'(1) : '0;
        S_ARMED: begin
          if (rx_fall) begin
            cnt      <= '0;
            s_len    <= '0;
            fall_cnt <= '0;
          end
        end
        S_MEASURE: begin
          cnt <= cnt_inc;
          // s_len is never legitimately zero, so zero marks "no rise seen yet".
          if (rx_rise && s_len == '0) s_len <= cnt_inc;
          if (rx_fall) begin
            fall_cnt <= fall_cnt + 3'd1;
            if (fall_cnt == 3'd3) c_len <= cnt_inc;
          end
        end
        S_UPDATE: begin
          final_value <= q_val;
          locked      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign timer_enable = 1'b1;
  assign timer_clr_n  = (state != S_UPDATE);
  assign busy         = (state != S_IDLE);
  assign error        = (state == S_FAIL);

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl: sync-character measurement, failures and reset.
module tb_uart_autobaud_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic rx, start;
  logic [10:0] final_value;
  logic timer_enable, timer_clr_n, busy, locked, error;

  logic rx2, start2;
  logic [3:0] final_value2;
  logic timer_enable2, timer_clr_n2, busy2, locked2, error2;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0, clr_pulses = 0, err2_pulses = 0;

  always #5 clk = ~clk;

  uart_autobaud_ctrl #(
    .BITS(11), .DEFAULT_FINAL(26), .IDLE_MIN(16), .MIN_FINAL(1)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .start(start),
    .final_value(final_value), .timer_enable(timer_enable),
    .timer_clr_n(timer_clr_n), .busy(busy), .locked(locked), .error(error)
  );

  // Narrow instance so counter saturation is reachable in a short run (2^11-1 cycles).
  uart_autobaud_ctrl #(
    .BITS(4), .DEFAULT_FINAL(5), .IDLE_MIN(16), .MIN_FINAL(1)
  ) dut_small (
    .clk(clk), .reset(reset), .rx(rx2), .start(start2),
    .final_value(final_value2), .timer_enable(timer_enable2),
    .timer_clr_n(timer_clr_n2), .busy(busy2), .locked(locked2), .error(error2)
  );

  always @(negedge clk) begin
    if (error)        err_pulses++;
    if (!timer_clr_n) clr_pulses++;
    if (error2)       err2_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic send_frame(input int s_len, input int b_len);
    logic [7:0] ch;
    ch = 8'h55;
    rx = 1'b0;
    wait_cycles(s_len);
    for (int i = 0; i < 8; i++) begin
      rx = ch[i];
      wait_cycles(b_len);
    end
    rx = 1'b1;
    wait_cycles(b_len);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 500) begin
      wait_cycles(1);
      k++;
    end
    check(tag, busy, 0);
  endtask

  task automatic run_detect(input string tag, input int s_len, input int b_len,
                            input int exp_final, input int exp_locked,
                            input int exp_err, input int exp_clr);
    int e0, c0;
    e0 = err_pulses;
    c0 = clr_pulses;
    rx = 1'b1;
    pulse_start();
    wait_cycles(20);
    send_frame(s_len, b_len);
    wait_idle({tag, "_done"});
    wait_cycles(2);
    check({tag, "_final"},  final_value, exp_final);
    check({tag, "_locked"}, locked, exp_locked);
    check({tag, "_err"},    err_pulses - e0, exp_err);
    check({tag, "_clr"},    clr_pulses - c0, exp_clr);
  endtask

  initial begin
    int k;
    reset = 1'b1; rx = 1'b1; start = 1'b0; rx2 = 1'b1; start2 = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);

    check("rst_final",  final_value, 26);
    check("rst_locked", locked, 0);
    check("rst_enable", timer_enable, 1);
    check("rst_clr_n",  timer_clr_n, 1);
    check("rst_busy",   busy, 0);
    check("rst_error",  error, 0);

    // 115200 baud at 50 MHz: C=3472, q=26.
    run_detect("b115k", 434, 434, 26, 1, 0, 1);
    // 9600 baud: C=41664, q=325.
    run_detect("b9600", 5208, 5208, 325, 1, 0, 1);
    check("en_hold", timer_enable, 1);
    // Ratio fail: S=434, C=2534 < 3038.
    run_detect("ratio", 434, 300, 325, 0, 1, 0);
    // Range fail: C=128 gives q=0.
    run_detect("range", 16, 16, 325, 0, 1, 0);

    // Saturation on the narrow instance: rx falls and never returns.
    k = err2_pulses;
    start2 = 1'b1;
    wait_cycles(1);
    start2 = 1'b0;
    wait_cycles(20);
    rx2 = 1'b0;
    begin
      int n;
      n = 0;
      while (err2_pulses == k && n < 3000) begin
        wait_cycles(1);
        n++;
      end
    end
    check("sat_err",    err2_pulses - k, 1);
    wait_cycles(2);
    check("sat_busy",   busy2, 0);
    check("sat_final",  final_value2, 5);
    check("sat_locked", locked2, 0);
    rx2 = 1'b1;

    // Reset during MEASURE, asserted away from any clock edge.
    rx = 1'b1;
    pulse_start();
    wait_cycles(20);
    rx = 1'b0;
    wait_cycles(100);
    check("mid_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_busy",   busy, 0);
    check("mid_final",  final_value, 26);
    check("mid_locked", locked, 0);
    check("mid_clr_n",  timer_clr_n, 1);
    check("mid_error",  error, 0);
    check("mid_enable", timer_enable, 1);
    rx = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(2);
    check("post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
